// File: rtl/sccb_slave.sv
// sccb_slave: SCCB target (camera-side responder) for the 2-wire OmniVision bus.
// SIO_C/SIO_D are oversampled on XCLK. START/STOP are decoded on the
// synchronized signals. The block handles 3-phase write, 2-phase write and
// 2-phase read transactions addressed to DEV_ID, and presents accesses on a
// simple register port.
//
// Ports:
//   XCLK, RST_N        system clock, async active-low reset
//   SIO_C, SIO_D_IN    bus clock and data pad input from the master
//   SIO_D_OUT/OE       data pad drive value and enable (OE=0 releases the line)
//   reg_addr           sub-address pointer; persists across transactions
//   reg_wdata/wr_en    write data with a one-cycle strobe per data-phase write
//   reg_rd_en/rdata    read fetch strobe; rdata is latched the cycle after it
//   busy               START..STOP while the transaction is addressed to us
module sccb_slave #(
  parameter logic [7:0] DEV_ID      = 8'h60,
  parameter bit         DRIVE_ACK   = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       XCLK,
  input  logic       RST_N,
  input  logic       SIO_C,
  input  logic       SIO_D_IN,
  output logic       SIO_D_OUT,
  output logic       SIO_D_OE,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X, S_WDATA, S_WDATA_X,
    S_RD_FETCH, S_RDATA, S_RD_NA, S_WAIT_STOP, S_IGNORE
  } state_t;

  // ---------------------------------------------------------------- input sync
  // Flops reset to 1 (idle bus) so leaving reset never fakes an edge.
  logic [SYNC_STAGES-1:0] c_sync, d_sync;
  logic c_q, d_q;
  logic c_s, d_s;

  always_ff @(posedge XCLK or negedge RST_N) begin
    if (!RST_N) begin
      c_sync <= '1;
      d_sync <= '1;
      c_q    <= 1'b1;
      d_q    <= 1'b1;
    end else begin
      c_sync <= {c_sync[SYNC_STAGES-2:0], SIO_C};
      d_sync <= {d_sync[SYNC_STAGES-2:0], SIO_D_IN};
      c_q    <= c_sync[SYNC_STAGES-1];
      d_q    <= d_sync[SYNC_STAGES-1];
    end
  end

  assign c_s = c_sync[SYNC_STAGES-1];
  assign d_s = d_sync[SYNC_STAGES-1];

  logic c_rise, c_fall, bus_start, bus_stop;
  assign c_rise    =  c_s & ~c_q;
  assign c_fall    = ~c_s &  c_q;
  // SIO_C must be high in both samples so a data change racing a clock edge
  // is never taken as a bus condition.
  assign bus_start = c_s & c_q &  d_q & ~d_s;
  assign bus_stop  = c_s & c_q & ~d_q &  d_s;

  // ---------------------------------------------------------------- state
  state_t     state, state_n;
  logic [7:0] sr, sr_n;
  logic [3:0] cnt, cnt_n;
  logic       xbit, xbit_n;       // X bit has been clocked in (rise seen)
  logic       rd_mode, rd_mode_n;
  logic       rd_pend, rd_pend_n; // rdata is latched the cycle after rd_en
  logic       oe_n, out_n, wr_en_n, rd_en_n, busy_n;
  logic [7:0] addr_n, wdata_n;

  always_ff @(posedge XCLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      sr        <= 8'h00;
      cnt       <= 4'd0;
      xbit      <= 1'b0;
      rd_mode   <= 1'b0;
      rd_pend   <= 1'b0;
      SIO_D_OE  <= 1'b0;
      SIO_D_OUT <= 1'b1;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      cnt       <= cnt_n;
      xbit      <= xbit_n;
      rd_mode   <= rd_mode_n;
      rd_pend   <= rd_pend_n;
      SIO_D_OE  <= oe_n;
      SIO_D_OUT <= out_n;
      reg_addr  <= addr_n;
      reg_wdata <= wdata_n;
      reg_wr_en <= wr_en_n;
      reg_rd_en <= rd_en_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    sr_n      = sr;
    cnt_n     = cnt;
    xbit_n    = xbit;
    rd_mode_n = rd_mode;
    rd_pend_n = rd_pend;
    oe_n      = SIO_D_OE;
    out_n     = SIO_D_OUT;
    addr_n    = reg_addr;
    wdata_n   = reg_wdata;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    busy_n    = busy;

    if (bus_stop) begin
      state_n   = S_IDLE;
      oe_n      = 1'b0;
      out_n     = 1'b1;
      cnt_n     = 4'd0;
      xbit_n    = 1'b0;
      rd_pend_n = 1'b0;
      busy_n    = 1'b0;
    end else if (bus_start) begin
      // Covers repeated START too; reg_addr is intentionally kept.
      state_n   = S_ID;
      oe_n      = 1'b0;
      out_n     = 1'b1;
      cnt_n     = 4'd0;
      xbit_n    = 1'b0;
      rd_pend_n = 1'b0;
      busy_n    = 1'b1;
    end else begin
      case (state)
        S_ID, S_SUB, S_WDATA: begin
          if (c_rise) begin
            sr_n = {sr[6:0], d_s};
            if (cnt == 4'd7) begin
              cnt_n  = 4'd8;
              xbit_n = 1'b0;
              case (state)
                S_ID: begin
                  if (sr_n[7:1] != DEV_ID[7:1]) begin
                    state_n = S_IGNORE;
                    busy_n  = 1'b0;
                  end else begin
                    rd_mode_n = sr_n[0];
                    state_n   = S_ID_X;
                  end
                end
                S_SUB: begin
                  addr_n  = sr_n;
                  state_n = S_SUB_X;
                end
                default: begin
                  wdata_n = sr_n;
                  wr_en_n = 1'b1;
                  state_n = S_WDATA_X;
                end
              endcase
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
        end

        // First fall (after bit 7) starts the ACK, the rise clocks the X bit,
        // the following fall ends the ACK and moves on.
        S_ID_X, S_SUB_X, S_WDATA_X: begin
          if (c_rise) xbit_n = 1'b1;
          if (c_fall && !xbit) begin
            oe_n  = DRIVE_ACK;
            out_n = ~DRIVE_ACK;
          end else if (c_fall && xbit) begin
            oe_n   = 1'b0;
            out_n  = 1'b1;
            cnt_n  = 4'd0;
            xbit_n = 1'b0;
            case (state)
              S_ID_X: begin
                if (rd_mode) begin
                  state_n = S_RD_FETCH;
                  rd_en_n = 1'b1;
                end else begin
                  state_n = S_SUB;
                end
              end
              S_SUB_X: state_n = S_WDATA;
              default: state_n = S_WAIT_STOP;
            endcase
          end
        end

        // SIO_C is low here, so bit 7 goes on the line as soon as it is loaded.
        S_RD_FETCH: begin
          if (reg_rd_en) begin
            rd_pend_n = 1'b1;
          end else if (rd_pend) begin
            rd_pend_n = 1'b0;
            sr_n      = {reg_rdata[6:0], 1'b0};
            oe_n      = 1'b1;
            out_n     = reg_rdata[7];
            cnt_n     = 4'd0;
            state_n   = S_RDATA;
          end
        end

        S_RDATA: begin
          if (c_rise) cnt_n = cnt + 4'd1;
          if (c_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              out_n   = 1'b1;
              state_n = S_RD_NA;
            end else begin
              out_n = sr[7];
              sr_n  = {sr[6:0], 1'b0};
            end
          end
        end

        // NA value is don't-care; only its clock matters.
        S_RD_NA: if (c_rise) state_n = S_WAIT_STOP;

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: directed bench for sccb_slave. A bit-banged master drives
// SIO_C/SIO_D over an open-drain bus model. A second instance with
// DRIVE_ACK=0 sees the same stimulus on its own bus and must never ACK.
module tb_sccb_slave;
  localparam int H = 20;  // XCLK cycles per SIO_C half period

  logic       XCLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       scl = 1'b1;
  logic       m_d = 1'b1;
  logic       bus1, bus2;
  logic       SIO_D_OUT, SIO_D_OE, reg_wr_en, reg_rd_en, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       out2, oe2, wr_en2, rd_en2, busy2;
  logic [7:0] addr2, wdata2;

  int n_vec = 0, n_err = 0;
  int in_kind = 0;  // 1 = master data/NA bit, 2 = write-byte X bit
  int oe_bad = 0, oe_any = 0, ack2_drv = 0;
  int wr_cnt = 0, rd_cnt = 0, wr_cnt2 = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;

  always #5 XCLK = ~XCLK;

  assign bus1 = m_d & (SIO_D_OE ? SIO_D_OUT : 1'b1);
  assign bus2 = m_d & (oe2 ? out2 : 1'b1);
  assign reg_rdata = (reg_addr == 8'h0A) ? 8'h44 :
                     (reg_addr == 8'h33) ? 8'hA5 : ~reg_addr;

  sccb_slave #(.DEV_ID(8'h60), .DRIVE_ACK(1'b1), .SYNC_STAGES(2)) dut (
    .XCLK(XCLK), .RST_N(RST_N), .SIO_C(scl), .SIO_D_IN(bus1),
    .SIO_D_OUT(SIO_D_OUT), .SIO_D_OE(SIO_D_OE),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  sccb_slave #(.DEV_ID(8'h60), .DRIVE_ACK(1'b0), .SYNC_STAGES(2)) dut_na (
    .XCLK(XCLK), .RST_N(RST_N), .SIO_C(scl), .SIO_D_IN(bus2),
    .SIO_D_OUT(out2), .SIO_D_OE(oe2),
    .reg_addr(addr2), .reg_wdata(wdata2),
    .reg_wr_en(wr_en2), .reg_rd_en(rd_en2),
    .reg_rdata(reg_rdata), .busy(busy2)
  );

  always @(negedge XCLK) begin
    if (in_kind == 1 && SIO_D_OE) oe_bad++;
    if (SIO_D_OE) oe_any++;
    if (in_kind == 2 && oe2) ack2_drv++;
    if (reg_wr_en) begin
      wr_cnt++;
      wr_addr = reg_addr;
      wr_data = reg_wdata;
    end
    if (reg_rd_en) rd_cnt++;
    if (wr_en2) wr_cnt2++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge XCLK);
  endtask

  task automatic m_start();
    m_d = 1'b1; cyc(H);
    scl = 1'b1; cyc(H);
    m_d = 1'b0; cyc(H);
    scl = 1'b0; cyc(6);
  endtask

  task automatic m_stop();
    m_d = 1'b0; cyc(H);
    scl = 1'b1; cyc(H);
    m_d = 1'b1; cyc(H);
  endtask

  task automatic bit_cyc(input logic b, input int kind, output logic s);
    in_kind = kind;
    m_d = b;    cyc(H);
    scl = 1'b1; cyc(H);
    s = bus1;
    scl = 1'b0;
    in_kind = 0;
    cyc(6);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cyc(v[i], 1, s);
    bit_cyc(1'b1, 2, s);
    ack = ~s;
  endtask

  task automatic rd_byte(output logic [7:0] v);
    logic s;
    v = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      bit_cyc(1'b1, 0, s);
      v[i] = s;
    end
    bit_cyc(1'b1, 1, s);  // NA
  endtask

  initial begin
    logic       a1, a2, a3, s;
    logic [7:0] rv;
    int         o0;

    // reset state
    cyc(3);
    chk("rst_oe",    32'(SIO_D_OE), 32'd0);
    chk("rst_out",   32'(SIO_D_OUT), 32'd1);
    chk("rst_addr",  32'(reg_addr), 32'h00);
    chk("rst_wdata", 32'(reg_wdata), 32'h00);
    chk("rst_wr",    32'(reg_wr_en), 32'd0);
    chk("rst_rd",    32'(reg_rd_en), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    RST_N = 1'b1;
    cyc(10);

    // 3-phase write 60/02/E3
    m_start();
    wr_byte(8'h60, a1); wr_byte(8'h02, a2); wr_byte(8'hE3, a3);
    chk("w3_acks", 32'({a1, a2, a3}), 32'b111);
    chk("w3_busy", 32'(busy), 32'd1);
    m_stop();
    chk("w3_wrcnt", 32'(wr_cnt), 32'd1);
    chk("w3_addr",  32'(wr_addr), 32'h02);
    chk("w3_data",  32'(wr_data), 32'hE3);
    chk("w3_busy_end", 32'(busy), 32'd0);
    chk("w3_oe_data", 32'(oe_bad), 32'd0);
    chk("w3_na_wr", 32'(wr_cnt2), 32'd1);

    // 2-phase write 60/0A, then 2-phase read 61
    m_start();
    wr_byte(8'h60, a1); wr_byte(8'h0A, a2);
    chk("w2_acks", 32'({a1, a2}), 32'b11);
    m_stop();
    chk("w2_addr",  32'(reg_addr), 32'h0A);
    chk("w2_wrcnt", 32'(wr_cnt), 32'd1);
    m_start();
    wr_byte(8'h61, a1);
    chk("rd_ack", 32'(a1), 32'd1);
    rd_byte(rv);
    chk("rd_data", 32'(rv), 32'h44);
    chk("rd_oe_after_na", 32'(SIO_D_OE), 32'd0);
    m_stop();
    chk("rd_cnt", 32'(rd_cnt), 32'd1);
    chk("rd_oe_na", 32'(oe_bad), 32'd0);

    // non-matching ID
    o0 = oe_any;
    m_start();
    wr_byte(8'h86, a1);
    chk("nm_ack", 32'(a1), 32'd0);
    chk("nm_busy", 32'(busy), 32'd0);
    wr_byte(8'h02, a2); wr_byte(8'h55, a3);
    m_stop();
    chk("nm_oe", 32'(oe_any - o0), 32'd0);
    chk("nm_wr", 32'(wr_cnt), 32'd1);
    chk("nm_rd", 32'(rd_cnt), 32'd1);
    chk("nm_addr", 32'(reg_addr), 32'h0A);

    // STOP after 4 data bits, then a normal write
    m_start();
    wr_byte(8'h60, a1); wr_byte(8'h02, a2);
    bit_cyc(1'b1, 1, s); bit_cyc(1'b0, 1, s);
    bit_cyc(1'b1, 1, s); bit_cyc(1'b1, 1, s);
    m_stop();
    chk("pb_wr",   32'(wr_cnt), 32'd1);
    chk("pb_busy", 32'(busy), 32'd0);
    chk("pb_oe",   32'(SIO_D_OE), 32'd0);
    chk("pb_addr", 32'(reg_addr), 32'h02);
    m_start();
    wr_byte(8'h60, a1); wr_byte(8'h05, a2); wr_byte(8'h5A, a3);
    m_stop();
    chk("pb2_acks", 32'({a1, a2, a3}), 32'b111);
    chk("pb2_wr",   32'(wr_cnt), 32'd2);
    chk("pb2_addr", 32'(wr_addr), 32'h05);
    chk("pb2_data", 32'(wr_data), 32'h5A);

    // repeated START after SUB_X, then read
    m_start();
    wr_byte(8'h60, a1); wr_byte(8'h33, a2);
    m_start();
    wr_byte(8'h61, a3);
    chk("rs_acks", 32'({a1, a2, a3}), 32'b111);
    rd_byte(rv);
    m_stop();
    chk("rs_data", 32'(rv), 32'hA5);
    chk("rs_addr", 32'(reg_addr), 32'h33);
    chk("rs_rd",   32'(rd_cnt), 32'd2);
    chk("rs_wr",   32'(wr_cnt), 32'd2);

    // reset mid-RDATA
    m_start();
    wr_byte(8'h61, a1);
    bit_cyc(1'b1, 0, s); bit_cyc(1'b1, 0, s); bit_cyc(1'b1, 0, s);
    chk("mr_oe_pre", 32'(SIO_D_OE), 32'd1);
    RST_N = 1'b0;
    #1;
    chk("mr_oe",    32'(SIO_D_OE), 32'd0);
    chk("mr_out",   32'(SIO_D_OUT), 32'd1);
    chk("mr_addr",  32'(reg_addr), 32'h00);
    chk("mr_wdata", 32'(reg_wdata), 32'h00);
    chk("mr_wr_rd", 32'({reg_wr_en, reg_rd_en}), 32'd0);
    chk("mr_busy",  32'(busy), 32'd0);
    scl = 1'b1; m_d = 1'b1;
    cyc(10);
    RST_N = 1'b1;
    cyc(10);
    m_start();
    wr_byte(8'h60, a1); wr_byte(8'h07, a2); wr_byte(8'hC3, a3);
    m_stop();
    chk("pr_acks", 32'({a1, a2, a3}), 32'b111);
    chk("pr_wr",   32'(wr_cnt), 32'd3);
    chk("pr_addr", 32'(wr_addr), 32'h07);
    chk("pr_data", 32'(wr_data), 32'hC3);
    m_start();
    wr_byte(8'h61, a1);
    rd_byte(rv);
    m_stop();
    chk("pr_rd_data", 32'(rv), 32'hF8);

    // DRIVE_ACK=0 instance: decodes writes but never ACKs
    chk("na_ack_drive", 32'(ack2_drv), 32'd0);
    chk("na_wr", 32'(wr_cnt2), 32'd3);
    chk("oe_in_master_bits", 32'(oe_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
- SCCB responder (camera-side target) for the OmniVision-style 2-wire bus driven by CoreSCCB.
- Oversamples SIO_C/SIO_D on XCLK and decodes START/STOP. Decodes 3-phase write, 2-phase write and 2-phase read transactions addressed to its device ID.
- Presents register writes and read fetches on a simple register port.
- Used as a synthesizable camera stand-in for closed-loop CoreSCCB testing and as a config target on the FPGA side.

Parameters:
- DEV_ID, 8'h60, 8-bit write ID. Read ID is DEV_ID|1. Bit 0 of DEV_ID is ignored on compare.
- DRIVE_ACK, 1, when 1 the slave pulls SIO_D low in the 9th (X) bit of each accepted written byte. When 0 the slave never drives in the X bit.
- SYNC_STAGES, 2, synchronizer depth for SIO_C and SIO_D_IN (minimum 2).

Ports:
- XCLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- SIO_C  in  1  SCCB clock from master.
- SIO_D_IN  in  1  SIO_D pad input.
- SIO_D_OUT  out  1  value driven on SIO_D when SIO_D_OE=1.
- SIO_D_OE  out  1  pad output enable; 0 = release (bus pulled high).
- reg_addr  out  8  current sub-address pointer.
- reg_wdata  out  8  write data, valid with reg_wr_en.
- reg_wr_en  out  1  one-XCLK pulse per completed data-phase write.
- reg_rd_en  out  1  one-XCLK pulse when read data is fetched.
- reg_rdata  in  8  read data; sampled on the XCLK after reg_rd_en.
- busy  out  1  high from START detect to STOP detect while ID matches.

Behaviour:
- Reset: SIO_D_OUT=1, SIO_D_OE=0, reg_addr=8'h00, reg_wdata=8'h00, reg_wr_en=0, reg_rd_en=0, busy=0. The state machine returns to IDLE. Reset mid-transaction releases SIO_D immediately (asynchronous).
- Input conditioning: SIO_C and SIO_D_IN pass through SYNC_STAGES flops. One more flop provides edge detect. The edge is detected SYNC_STAGES+1 XCLK after the pin transition.
- Bus conditions, evaluated on synchronized signals:
  - START = SIO_D falls while SIO_C high.
  - STOP = SIO_D rises while SIO_C high.
  - Data is sampled on SIO_C rising edge. The slave changes SIO_D only on SIO_C falling edge, one XCLK after detection.
- Master SIO_C high/low times must be at least SYNC_STAGES+3 XCLK; the 100 kHz SIO_C at 50 MHz XCLK is well inside this.
- Bit counter is 4 bits and counts 0..8 per 9-bit phase. Bits are MSB first; bit 8 is the X bit.
- States:
  - IDLE: wait for START, then go to ID.
  - ID: shift 8 bits.
    - On 8th rise, if id[7:1]!=DEV_ID[7:1], go to IGNORE.
    - Otherwise, id[0]=0 goes to ID_X with mode=write; id[0]=1 goes to ID_X with mode=read.
  - ID_X: drive ACK (if DRIVE_ACK) during the X bit. Then write mode goes to SUB; read mode goes to RD_FETCH.
  - SUB: shift 8 bits. On completion load reg_addr, then go to SUB_X (ACK as above), then to WDATA.
  - WDATA: shift 8 bits. On completion set reg_wdata and pulse reg_wr_en with reg_addr, then go to WDATA_X (ACK), then to WAIT_STOP.
  - RD_FETCH: pulse reg_rd_en one XCLK after the ID_X falling edge. Latch reg_rdata into the shift register the next XCLK, then go to RDATA.
  - RDATA: SIO_D_OE=1. SIO_D_OUT takes the next data bit on each SIO_C fall, starting from bit 7. After the 8th bit's fall, release OE, then go to RD_NA.
  - RD_NA: sample the master NA bit; the value is ignored. Then go to WAIT_STOP.
  - WAIT_STOP and IGNORE: never drive SIO_D; wait for STOP or START.
- STOP in any state: release SIO_D and go to IDLE; busy falls.
  - A 2-phase write (STOP after SUB_X) only updates reg_addr.
  - A partial byte is discarded and no reg_wr_en is issued.
- START in any state (repeated start): release SIO_D, clear the bit counter, go to ID. reg_addr is retained.
- ACK drive: SIO_D_OE=1 with SIO_D_OUT=0 from the SIO_C fall after bit 7 to the SIO_C fall after bit 8.
- reg_addr persists across transactions. A 2-phase read uses the last written sub-address. There is no auto-increment.
- Extra bytes after WDATA_X or RD_NA are ignored and not ACKed.

Test Plan:
- 3-phase write: START, 0x60, 0x02, 0xE3, STOP → reg_wr_en pulses exactly once with reg_addr=0x02 and reg_wdata=0xE3. SIO_D is low in all three X bits and never driven elsewhere.
- 2-phase write 0x60/0x0A then 2-phase read 0x61 with reg_rdata=0x44 → reg_addr=0x0A, one reg_rd_en pulse. Master samples 0x44 MSB-first, and OE=0 during the NA bit and after.
- Non-matching ID 0x86 full write → SIO_D_OE stays 0, no reg_wr_en/reg_rd_en, busy=0, reg_addr unchanged.
- STOP after 4 data bits of a 3-phase write → no reg_wr_en, state IDLE, OE=0. A following valid write completes normally.
- Repeated START after SUB_X, then read ID 0x61 → read returns reg_rdata for the newly written sub-address.
- RST_N asserted mid-RDATA while OE=1 → OE=0 within the same cycle and all outputs at reset values. After release, the next transaction decodes correctly. Repeat with DRIVE_ACK=0: no ACK drive ever.
